axil_ipif_bridge: RTL and testbench

AXI4-Lite slave front end that converts single-beat AXI4-Lite reads and writes into the one-chip-select Bus2IP/IP2Bus register interface used by our register peripherals, such as the module identifier ROM. It sits directly upstream of a peripheral's register logic. It owns:
- address decode against one BAR,
- read/write arbitration,
- the data-phase timeout,
- error response generation.

---
 rtl/axil_ipif_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_ipif_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ipif_bridge.sv
// AXI4-Lite slave to single chip-select Bus2IP/IP2Bus bridge: one outstanding
// transaction, BAR decode, data-phase timeout and SLVERR generation.
module axil_ipif_bridge #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_USE_WSTRB        = 0,
   parameter int C_DPHASE_TIMEOUT   = 8,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_BASEADDR = '1,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_HIGHADDR = '0
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              Bus2IP_Clk,
   output logic                              Bus2IP_Resetn,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
   output logic                              Bus2IP_CS,
   output logic                              Bus2IP_RNW,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
   input  logic                              IP2Bus_RdAck,
   input  logic                              IP2Bus_WrAck,
   input  logic                              IP2Bus_Error
);

   localparam int BEW = C_S_AXI_DATA_WIDTH / 8;
   localparam int TW  = (C_DPHASE_TIMEOUT > 1) ? $clog2(C_DPHASE_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((C_DPHASE_TIMEOUT > 0) ? C_DPHASE_TIMEOUT - 1 : 0);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, RD_ACCESS, WR_ACCESS, RD_RESP, WR_RESP} state_t;

   state_t                        state_q, state_d;
   logic                          awready_q, awready_d;
   logic                          wready_q, wready_d;
   logic                          arready_q, arready_d;
   logic                          bvalid_q, bvalid_d;
   logic                          rvalid_q, rvalid_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic [1:0]                    rresp_q, rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BEW-1:0]                be_q, be_d;
   logic                          cs_q, cs_d;
   logic                          rnw_q, rnw_d;
   logic                          last_wr_q, last_wr_d;
   logic [TW-1:0]                 timer_q, timer_d;

   logic in_range;
   logic wr_elig;
   logic timed_out;

   assign in_range  = (addr_q >= C_BAR0_BASEADDR) && (addr_q <= C_BAR0_HIGHADDR);
   assign wr_elig   = S_AXI_AWVALID && S_AXI_WVALID;
   assign timed_out = (C_DPHASE_TIMEOUT != 0) && (timer_q == T_LAST);

   // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      arready_d = 1'b0;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      bresp_d   = bresp_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      cs_d      = cs_q;
      rnw_d     = rnw_q;
      last_wr_d = last_wr_q;
      timer_d   = timer_q;

      case (state_q)
         IDLE: begin
            // The READY pulse cycle is the grant cycle; decode the latched address as it ends.
            if (arready_q) begin
               if (in_range) begin
                  state_d = RD_ACCESS;
                  cs_d    = 1'b1;
                  timer_d = '0;
               end else begin
                  state_d  = RD_RESP;
                  rvalid_d = 1'b1;
                  rresp_d  = RESP_SLVERR;
                  rdata_d  = '0;
               end
            end else if (awready_q) begin
               if (in_range) begin
                  state_d = WR_ACCESS;
                  cs_d    = 1'b1;
                  timer_d = '0;
               end else begin
                  state_d  = WR_RESP;
                  bvalid_d = 1'b1;
                  bresp_d  = RESP_SLVERR;
               end
            end else if (S_AXI_ARVALID && (!wr_elig || last_wr_q)) begin
               arready_d = 1'b1;
               addr_d    = S_AXI_ARADDR;
               be_d      = '1;
               rnw_d     = 1'b1;
            end else if (wr_elig) begin
               awready_d = 1'b1;
               wready_d  = 1'b1;
               addr_d    = S_AXI_AWADDR;
               wdata_d   = S_AXI_WDATA;
               be_d      = (C_USE_WSTRB != 0) ? S_AXI_WSTRB : '1;
               rnw_d     = 1'b0;
            end
         end
         RD_ACCESS: begin
            if (IP2Bus_RdAck) begin
               state_d  = RD_RESP;
               cs_d     = 1'b0;
               rvalid_d = 1'b1;
               rdata_d  = IP2Bus_Data;
               rresp_d  = IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
            end else if (timed_out) begin
               state_d  = RD_RESP;
               cs_d     = 1'b0;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               rresp_d  = RESP_SLVERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WR_ACCESS: begin
            if (IP2Bus_WrAck) begin
               state_d  = WR_RESP;
               cs_d     = 1'b0;
               bvalid_d = 1'b1;
               bresp_d  = IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
            end else if (timed_out) begin
               state_d  = WR_RESP;
               cs_d     = 1'b0;
               bvalid_d = 1'b1;
               bresp_d  = RESP_SLVERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RD_RESP: begin
            if (S_AXI_RREADY) begin
               state_d   = IDLE;
               rvalid_d  = 1'b0;
               last_wr_d = 1'b0;
            end
         end
         WR_RESP: begin
            if (S_AXI_BREADY) begin
               state_d   = IDLE;
               bvalid_d  = 1'b0;
               last_wr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         // NOTE: the data/address latches are reset too, since they drive ports with defined reset values.
         state_q   <= IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '1;
         cs_q      <= 1'b0;
         rnw_q     <= 1'b1;
         last_wr_q <= 1'b1;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         cs_q      <= cs_d;
         rnw_q     <= rnw_d;
         last_wr_q <= last_wr_d;
         timer_q   <= timer_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign Bus2IP_Clk    = S_AXI_ACLK;
   assign Bus2IP_Resetn = S_AXI_ARESETN;
   assign Bus2IP_Addr   = addr_q;
   assign Bus2IP_CS     = cs_q;
   assign Bus2IP_RNW    = rnw_q;
   assign Bus2IP_Data   = wdata_q;
   assign Bus2IP_BE     = be_q;

endmodule

// File: tb/tb_axil_ipif_bridge.sv
// Directed bench for axil_ipif_bridge: a WSTRB-forwarding instance plus a twin with
// WSTRB ignored, driven by the same stimulus and a simple delayed-ack peripheral model.
module tb_axil_ipif_bridge;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;

   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        ip_clk, ip_resetn, cs, rnw;
   logic [31:0] ip_addr, ip_wdata;
   logic [3:0]  ip_be;

   logic        nb_awready, nb_wready, nb_bvalid, nb_arready, nb_rvalid;
   logic [1:0]  nb_bresp, nb_rresp;
   logic [31:0] nb_rdata;
   logic        nb_ip_clk, nb_ip_resetn, nb_cs, nb_rnw;
   logic [31:0] nb_ip_addr, nb_ip_wdata;
   logic [3:0]  nb_ip_be;

   // Peripheral model: acks ack_delay cycles after CS rises (never if negative), holds until CS falls
   int          ack_delay;
   logic [31:0] ack_data;
   logic        ack_err;
   int          cs_cnt;
   logic        ack_on, rd_ack, wr_ack;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cs_cnt <= cs ? cs_cnt + 1 : 0;
   assign ack_on = cs && (ack_delay >= 0) && (cs_cnt >= ack_delay);
   assign rd_ack = ack_on && rnw;
   assign wr_ack = ack_on && !rnw;

   axil_ipif_bridge #(
      .C_USE_WSTRB(1), .C_DPHASE_TIMEOUT(8),
      .C_BAR0_BASEADDR(32'h0000_1000), .C_BAR0_HIGHADDR(32'h0000_1FFF)
   ) u_dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .Bus2IP_Clk(ip_clk), .Bus2IP_Resetn(ip_resetn), .Bus2IP_Addr(ip_addr),
      .Bus2IP_CS(cs), .Bus2IP_RNW(rnw), .Bus2IP_Data(ip_wdata), .Bus2IP_BE(ip_be),
      .IP2Bus_Data(ack_data), .IP2Bus_RdAck(rd_ack), .IP2Bus_WrAck(wr_ack), .IP2Bus_Error(ack_err)
   );

   axil_ipif_bridge #(
      .C_USE_WSTRB(0), .C_DPHASE_TIMEOUT(8),
      .C_BAR0_BASEADDR(32'h0000_1000), .C_BAR0_HIGHADDR(32'h0000_1FFF)
   ) u_dut_nb (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(nb_awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(nb_wready),
      .S_AXI_BRESP(nb_bresp), .S_AXI_BVALID(nb_bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(nb_arready),
      .S_AXI_RDATA(nb_rdata), .S_AXI_RRESP(nb_rresp), .S_AXI_RVALID(nb_rvalid), .S_AXI_RREADY(rready),
      .Bus2IP_Clk(nb_ip_clk), .Bus2IP_Resetn(nb_ip_resetn), .Bus2IP_Addr(nb_ip_addr),
      .Bus2IP_CS(nb_cs), .Bus2IP_RNW(nb_rnw), .Bus2IP_Data(nb_ip_wdata), .Bus2IP_BE(nb_ip_be),
      .IP2Bus_Data(ack_data), .IP2Bus_RdAck(rd_ack), .IP2Bus_WrAck(wr_ack), .IP2Bus_Error(ack_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Cycle 0 is the ARREADY cycle; t_valid is the cycle RVALID is first seen.
   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output int t_valid, output int cs_cycles, output logic [31:0] data,
                           output logic [1:0] resp, output logic stable, output logic aw_seen);
      int n, c;
      cs_cycles = 0; stable = 1'b1; aw_seen = 1'b0;
      arvalid = 1'b1; araddr = addr;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk); n++;
         if (awready) aw_seen = 1'b1;
      end
      check("rd_grant", 32'(arready), 32'd1);
      c = 0;
      while (!rvalid && c < 40) begin
         @(negedge clk); c++;
         if (c == 1) arvalid = 1'b0;
         if (cs) cs_cycles++;
         if (awready) aw_seen = 1'b1;
      end
      t_valid = c; data = rdata; resp = rresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
         if (awready) aw_seen = 1'b1;
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   // Called at a negedge. Bus2IP_* of both instances are captured in cycle 1.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output int t_valid, output int cs_cycles, output logic [1:0] resp,
                            output logic [31:0] cap_addr, output logic [31:0] cap_data,
                            output logic [3:0] cap_be, output logic [3:0] cap_be_nb, output logic cap_rnw);
      int n, c;
      cs_cycles = 0;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
      n = 0;
      while (!(awready && wready) && n < 20) begin
         @(negedge clk); n++;
      end
      check("wr_grant", 32'(awready && wready), 32'd1);
      c = 0;
      cap_addr = '0; cap_data = '0; cap_be = '0; cap_be_nb = '0; cap_rnw = 1'b1;
      while (!bvalid && c < 40) begin
         @(negedge clk); c++;
         if (c == 1) begin
            awvalid = 1'b0; wvalid = 1'b0;
            cap_addr = ip_addr; cap_data = ip_wdata; cap_be = ip_be; cap_be_nb = nb_ip_be; cap_rnw = rnw;
         end
         if (cs) cs_cycles++;
      end
      t_valid = c; resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   initial begin
      int          tv, cc;
      logic [31:0] d, ca, cd;
      logic [1:0]  r;
      logic [3:0]  be, be_nb;
      logic        st, aw, rw;
      int          n;

      aresetn = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      ack_delay = 0; ack_data = '0; ack_err = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_cs", 32'(cs), 32'd0);
      check("rst_rnw", 32'(rnw), 32'd1);
      check("rst_bresp", 32'(bresp), 32'd0);
      check("rst_rresp", 32'(rresp), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr", ip_addr, 32'd0);
      check("rst_data", ip_wdata, 32'd0);
      check("rst_be", 32'(ip_be), 32'hF);

      aresetn = 1'b1;
      @(negedge clk);

      // AW/W and AR valid together after reset: read first, write blocked while RREADY held low
      ack_delay = 0; ack_data = 32'hCAFE_0001; ack_err = 1'b0;
      awaddr = 32'h0000_1004; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      axi_read(32'h0000_1000, 5, tv, cc, d, r, st, aw);
      check("arb_rd_data", d, 32'hCAFE_0001);
      check("arb_rd_resp", 32'(r), 32'd0);
      check("arb_rd_tvalid", tv, 2);
      check("arb_rd_stable", 32'(st), 32'd1);
      check("arb_aw_blocked", 32'(aw), 32'd0);
      axi_write(32'h0000_1004, 32'h0BAD_F00D, 4'hF, tv, cc, r, ca, cd, be, be_nb, rw);
      check("arb_wr_resp", 32'(r), 32'd0);
      check("arb_wr_data", cd, 32'h0BAD_F00D);

      // Read with RdAck two cycles after CS
      ack_delay = 2; ack_data = 32'hDEAD_BEEF;
      axi_read(32'h0000_1020, 0, tv, cc, d, r, st, aw);
      check("rd_data", d, 32'hDEAD_BEEF);
      check("rd_resp", 32'(r), 32'd0);
      check("rd_tvalid", tv, 4);
      check("rd_cs_cycles", cc, 3);

      // Write with WSTRB=0x3, one-cycle-late WrAck
      ack_delay = 1;
      axi_write(32'h0000_1008, 32'h1234_5678, 4'h3, tv, cc, r, ca, cd, be, be_nb, rw);
      check("wr_resp", 32'(r), 32'd0);
      check("wr_tvalid", tv, 3);
      check("wr_cs_cycles", cc, 2);
      check("wr_ip_addr", ca, 32'h0000_1008);
      check("wr_ip_data", cd, 32'h1234_5678);
      check("wr_be_strb", 32'(be), 32'h3);
      check("wr_be_nostrb", 32'(be_nb), 32'hF);
      check("wr_rnw", 32'(rw), 32'd0);

      // Peripheral error on a read: data still captured, SLVERR
      ack_delay = 0; ack_data = 32'hA5A5_A5A5; ack_err = 1'b1;
      axi_read(32'h0000_1030, 0, tv, cc, d, r, st, aw);
      ack_err = 1'b0;
      check("err_rd_resp", 32'(r), 32'h2);
      check("err_rd_data", d, 32'hA5A5_A5A5);

      // Just above HIGHADDR and just below BASEADDR
      axi_read(32'h0000_2000, 0, tv, cc, d, r, st, aw);
      check("oor_rd_resp", 32'(r), 32'h2);
      check("oor_rd_data", d, 32'd0);
      check("oor_rd_tvalid", tv, 1);
      check("oor_rd_cs", cc, 0);
      axi_write(32'h0000_0FFC, 32'h5555_AAAA, 4'hF, tv, cc, r, ca, cd, be, be_nb, rw);
      check("oor_wr_resp", 32'(r), 32'h2);
      check("oor_wr_tvalid", tv, 1);
      check("oor_wr_cs", cc, 0);

      // HIGHADDR itself is in range
      ack_data = 32'h1111_2222;
      axi_read(32'h0000_1FFF, 0, tv, cc, d, r, st, aw);
      check("hi_rd_resp", 32'(r), 32'd0);
      check("hi_rd_data", d, 32'h1111_2222);

      // No ack ever: CS high exactly 8 cycles
      ack_delay = -1;
      axi_read(32'h0000_1010, 0, tv, cc, d, r, st, aw);
      check("to_cs_cycles", cc, 8);
      check("to_tvalid", tv, 9);
      check("to_resp", 32'(r), 32'h2);
      check("to_data", d, 32'd0);

      // Reset while CS is high drops the transaction
      arvalid = 1'b1; araddr = 32'h0000_1040;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk); n++;
      end
      check("mid_grant", 32'(arready), 32'd1);
      @(negedge clk); arvalid = 1'b0;
      @(negedge clk);
      check("mid_cs_high", 32'(cs), 32'd1);
      aresetn = 1'b0;
      @(negedge clk);
      check("mid_rst_cs", 32'(cs), 32'd0);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      aresetn = 1'b1;
      @(negedge clk);
      ack_delay = 0; ack_data = 32'h600D_0001;
      axi_read(32'h0000_1044, 0, tv, cc, d, r, st, aw);
      check("post_rst_resp", 32'(r), 32'd0);
      check("post_rst_data", d, 32'h600D_0001);
      check("post_rst_tvalid", tv, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
